// File: rtl/cpu_mult_arb_pkg.sv
// Shared types for the multiplier arbiter: data width, in-flight tag, response
// FIFO entry, and the requester-ID width helper.
package cpu_mult_arb_pkg;
   localparam int DATA_W   = 32;
   // Widest ID needed for NUM_REQ up to 8; narrower configs zero-extend.
   localparam int ID_MAX_W = 3;

   typedef struct packed {
      logic                valid;
      logic [ID_MAX_W-1:0] id;
   } tag_t;

   typedef struct packed {
      logic [ID_MAX_W-1:0] id;
      logic [DATA_W-1:0]   result;
   } rsp_entry_t;

   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/cpu_mult_rsp_fifo.sv
// Synchronous response FIFO with occupancy count.
// Ports: clk_i/rst_ni (sync, active-low), wr_en_i/wr_data_i enqueue,
//        rd_en_i dequeue request (ignored when empty), rd_valid_o/rd_data_o
//        head entry, count_o registered occupancy.
module cpu_mult_rsp_fifo #(
   parameter  int WIDTH = 35,
   parameter  int DEPTH = 4,
   localparam int PTR_W = (DEPTH <= 2) ? 1 : $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic             rd_valid_o,
   output logic [WIDTH-1:0] rd_data_o,
   output logic [CNT_W-1:0] count_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_rd;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign do_rd      = rd_en_i && (cnt_q != '0);
   assign rd_valid_o = (cnt_q != '0);
   assign rd_data_o  = mem_q[rd_ptr_q];
   assign count_o    = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      case ({wr_en_i, do_rd})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         // Upstream credit accounting must keep us from ever seeing this.
         assert (!(wr_en_i && cnt_q == CNT_W'(DEPTH)));
         if (wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (do_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/cpu_mult_arbiter.sv
// Shares one pipelined 32x32 low-product multiplier cell among NUM_REQ
// requesters. Round-robin grant, tag pipeline matched to cell latency, and a
// credit-protected response FIFO.
// Ports: clk/reset_n (sync, active-low); req_valid/req_ready/req_src1/req_src2
//        requester side (operands packed 32 bits per requester);
//        M_mul_src1/M_mul_src2/M_mul_cell_result cell side;
//        rsp_valid/rsp_ready/rsp_id/rsp_result response side; busy.
module cpu_mult_arbiter
   import cpu_mult_arb_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int ID_W       = id_width(NUM_REQ),
   parameter int LATENCY    = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_src1,
   input  logic [NUM_REQ*DATA_W-1:0] req_src2,
   output logic [DATA_W-1:0]         M_mul_src1,
   output logic [DATA_W-1:0]         M_mul_src2,
   input  logic [DATA_W-1:0]         M_mul_cell_result,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic [DATA_W-1:0]         rsp_result,
   output logic                      busy
);
   localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int OCC_W  = $clog2(FIFO_DEPTH + LATENCY + 1) + 1;

   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d, gnt;
   logic              any_valid, credit_ok, grant_ok, issue, tag_busy;
   logic [OCC_W-1:0]  occ;
   logic [FCNT_W-1:0] fifo_cnt;
   tag_t              tag_q [LATENCY];
   rsp_entry_t        wr_entry, rd_entry;

   // First valid requester at or after rr_ptr, wrapping.
   always_comb begin
      int idx;
      idx       = 0;
      gnt       = rr_ptr_q;
      any_valid = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (!any_valid && req_valid[idx]) begin
            any_valid = 1'b1;
            gnt       = ID_W'(idx);
         end
      end
   end

   // Occupancy uses the registered FIFO count: a same-cycle pop does not
   // free a slot, which keeps rsp_ready off the req_ready path.
   always_comb begin
      occ      = OCC_W'(fifo_cnt);
      tag_busy = 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
         occ      = occ + OCC_W'(tag_q[i].valid);
         tag_busy = tag_busy | tag_q[i].valid;
      end
   end

   assign credit_ok = occ < OCC_W'(FIFO_DEPTH);
   assign grant_ok  = any_valid & credit_ok & reset_n;
   assign issue     = grant_ok;
   assign rr_ptr_d  = !issue ? rr_ptr_q :
                      (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;

   always_comb begin
      req_ready  = '0;
      M_mul_src1 = '0;
      M_mul_src2 = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt == ID_W'(i)) begin
            req_ready[i] = grant_ok;
            if (any_valid) begin
               M_mul_src1 = req_src1[i*DATA_W +: DATA_W];
               M_mul_src2 = req_src2[i*DATA_W +: DATA_W];
            end
         end
      end
   end

   // Tag pipeline: stage LATENCY-1 lines up with the cell's output.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rr_ptr_q <= '0;
         for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         tag_q[0] <= '{valid: issue, id: ID_MAX_W'(gnt)};
         for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
         assert (!rsp_valid || rd_entry.id < ID_MAX_W'(NUM_REQ));
      end
   end

   assign wr_entry.id     = tag_q[LATENCY-1].id;
   assign wr_entry.result = M_mul_cell_result;

   cpu_mult_rsp_fifo #(
      .WIDTH ($bits(rsp_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_rsp_fifo (
      .clk_i      (clk),
      .rst_ni     (reset_n),
      .wr_en_i    (tag_q[LATENCY-1].valid),
      .wr_data_i  (wr_entry),
      .rd_en_i    (rsp_ready),
      .rd_valid_o (rsp_valid),
      .rd_data_o  (rd_entry),
      .count_o    (fifo_cnt)
   );

   assign rsp_id     = rd_entry.id[ID_W-1:0];
   assign rsp_result = rd_entry.result;
   assign busy       = tag_busy | (fifo_cnt != '0);
endmodule
